// File: rtl/traffic_injector.sv
`default_nettype none
// ============================================================================
// Module   : traffic_injector
// Summary  : Holds packet descriptors until their injection cycle, splits them
//            into flits and meters them into the router with per-VC credits.
// Options  : define INJ_STATS_EN to add the stat_flits / stat_stall counters.
// Revision : 1.0
// ============================================================================
module traffic_injector #(
  parameter int NUMVCS  = 4,
  parameter int VCBUFSZ = 4,
  parameter int QDEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [15:0] load_cycle,
  input  logic [13:0] load_dest,
  input  logic [3:0]  load_len,
  output logic        load_ready,
  input  logic [15:0] in_cycle,
  input  logic        can_inject,
  input  logic [21:0] cr_in,
  output logic [21:0] out_flit,
  output logic        busy
`ifdef INJ_STATS_EN
  ,
  output logic [31:0] stat_flits,
  output logic [31:0] stat_stall
`endif
);

  localparam int C_VCW  = (NUMVCS > 1) ? $clog2(NUMVCS) : 1;
  localparam int C_CW   = $clog2(VCBUFSZ + 1);
  localparam int C_AW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int C_CNTW = $clog2(QDEPTH + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // Descriptor FIFO storage
  logic [15:0]       fifo_cycle_q [QDEPTH];
  logic [13:0]       fifo_dest_q  [QDEPTH];
  logic [3:0]        fifo_len_q   [QDEPTH];
  logic [C_AW-1:0]   wr_ptr_q;
  logic [C_AW-1:0]   rd_ptr_q;
  logic [C_CNTW-1:0] count_q;

  // Packet in flight and credit state
  state_t            state_q;
  logic [C_VCW-1:0]  vc_q;
  logic [C_VCW-1:0]  rr_q;
  logic [3:0]        rem_q;
  logic [13:0]       dest_q;
  logic [C_CW-1:0]   credit_q [NUMVCS];
  logic [21:0]       out_flit_q;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_head_due;
  logic [3:0]        w_head_len;
  logic              w_sel_found;
  logic [C_VCW-1:0]  w_sel_vc;
  logic [C_VCW-1:0]  w_rr_next;
  logic              w_start;
  logic              w_cont;
  logic              w_emit;
  logic [C_VCW-1:0]  w_emit_vc;
  logic [1:0]        w_flit_type;
  logic [13:0]       w_emit_dest;
  logic [NUMVCS-1:0] w_cr_inc;
  logic [NUMVCS-1:0] w_cr_dec;
  logic              w_unused;

  assign w_unused   = ^cr_in[15:0];
  assign w_full     = (count_q == C_CNTW'(QDEPTH));
  assign w_empty    = (count_q == '0);
  assign w_push     = load_valid && !w_full;
  assign w_head_due = !w_empty && (in_cycle >= fifo_cycle_q[rd_ptr_q]);
  assign w_head_len = (fifo_len_q[rd_ptr_q] == 4'd0) ? 4'd1 : fifo_len_q[rd_ptr_q];

  // Round-robin search for a VC with credit, starting at the pointer
  always_comb begin : p_rr
    int idx;
    idx         = 0;
    w_sel_found = 1'b0;
    w_sel_vc    = '0;
    for (int i = 0; i < NUMVCS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUMVCS) idx = idx - NUMVCS;
      if (!w_sel_found && (credit_q[idx[C_VCW-1:0]] != '0)) begin
        w_sel_found = 1'b1;
        w_sel_vc    = idx[C_VCW-1:0];
      end
    end
  end

  assign w_rr_next = (w_sel_vc == C_VCW'(NUMVCS - 1)) ? '0 : (w_sel_vc + C_VCW'(1));

  assign w_start = (state_q == S_IDLE) && w_head_due && can_inject && w_sel_found;
  assign w_cont  = (state_q == S_SEND) && can_inject && (credit_q[vc_q] != '0);
  assign w_emit  = w_start || w_cont;

  assign w_emit_vc   = w_start ? w_sel_vc : vc_q;
  assign w_emit_dest = w_start ? fifo_dest_q[rd_ptr_q] : dest_q;

  always_comb begin
    w_flit_type = 2'b00;
    if (w_start) begin
      w_flit_type = (w_head_len == 4'd1) ? 2'b11 : 2'b01;
    end else if (rem_q == 4'd1) begin
      w_flit_type = 2'b10;
    end
  end

  // A credit for a VC outside the configured range matches no counter
  always_comb begin
    w_cr_inc = '0;
    w_cr_dec = '0;
    for (int v = 0; v < NUMVCS; v++) begin
      w_cr_inc[v] = cr_in[21] && (cr_in[20:16] == 5'(v));
      w_cr_dec[v] = w_emit && (w_emit_vc == C_VCW'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      vc_q       <= '0;
      rr_q       <= '0;
      rem_q      <= '0;
      dest_q     <= '0;
      out_flit_q <= '0;
      for (int v = 0; v < NUMVCS; v++) begin
        credit_q[v] <= C_CW'(VCBUFSZ);
      end
    end else begin
      if (w_push) begin
        fifo_cycle_q[wr_ptr_q] <= load_cycle;
        fifo_dest_q[wr_ptr_q]  <= load_dest;
        fifo_len_q[wr_ptr_q]   <= load_len;
        wr_ptr_q <= (wr_ptr_q == C_AW'(QDEPTH - 1)) ? '0 : (wr_ptr_q + C_AW'(1));
      end
      if (w_start) begin
        rd_ptr_q <= (rd_ptr_q == C_AW'(QDEPTH - 1)) ? '0 : (rd_ptr_q + C_AW'(1));
      end
      if (w_push && !w_start) begin
        count_q <= count_q + C_CNTW'(1);
      end else if (!w_push && w_start) begin
        count_q <= count_q - C_CNTW'(1);
      end

      out_flit_q <= w_emit ? {1'b1, 5'(w_emit_vc), w_flit_type, w_emit_dest} : '0;

      case (state_q)
        S_IDLE: begin
          if (w_start) begin
            rr_q   <= w_rr_next;
            vc_q   <= w_sel_vc;
            dest_q <= fifo_dest_q[rd_ptr_q];
            rem_q  <= w_head_len - 4'd1;
            if (w_head_len != 4'd1) begin
              state_q <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (w_cont) begin
            rem_q <= rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Return and consume on the same VC cancel out
      for (int v = 0; v < NUMVCS; v++) begin
        if (w_cr_inc[v] && !w_cr_dec[v] && (credit_q[v] != C_CW'(VCBUFSZ))) begin
          credit_q[v] <= credit_q[v] + C_CW'(1);
        end else if (w_cr_dec[v] && !w_cr_inc[v]) begin
          credit_q[v] <= credit_q[v] - C_CW'(1);
        end
      end
    end
  end

  assign out_flit   = out_flit_q;
  assign load_ready = !w_full;
  assign busy       = !w_empty || (state_q == S_SEND);

`ifdef INJ_STATS_EN
  logic        w_stall;
  logic [31:0] stat_flits_q;
  logic [31:0] stat_stall_q;

  // Blocked means work was ready but the router or credits held it back
  assign w_stall = ((state_q == S_IDLE) && w_head_due && !w_start) ||
                   ((state_q == S_SEND) && !w_cont);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flits_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (w_emit)  stat_flits_q <= stat_flits_q + 32'd1;
      if (w_stall) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_flits = stat_flits_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_traffic_injector.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_injector
// Summary  : Scoreboard bench for traffic_injector (default 4 VCs, 4 credits,
//            8-entry FIFO); stat counters checked when INJ_STATS_EN is set.
// Revision : 1.0
// ============================================================================
module tb_traffic_injector;

  localparam int NUMVCS  = 4;
  localparam int VCBUFSZ = 4;
  localparam int QDEPTH  = 8;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_cycle = '0;
  logic [13:0] load_dest  = '0;
  logic [3:0]  load_len   = '0;
  logic        load_ready;
  logic [15:0] in_cycle   = '0;
  logic        can_inject = 1'b1;
  logic [21:0] cr_in      = '0;
  logic [21:0] out_flit;
  logic        busy;
`ifdef INJ_STATS_EN
  logic [31:0] stat_flits;
  logic [31:0] stat_stall;
`endif

  traffic_injector #(
    .NUMVCS (NUMVCS),
    .VCBUFSZ(VCBUFSZ),
    .QDEPTH (QDEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_cycle(load_cycle),
    .load_dest (load_dest),
    .load_len  (load_len),
    .load_ready(load_ready),
    .in_cycle  (in_cycle),
    .can_inject(can_inject),
    .cr_in     (cr_in),
    .out_flit  (out_flit),
    .busy      (busy)
`ifdef INJ_STATS_EN
    ,
    .stat_flits(stat_flits),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] flit;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [21:0] mkflit(input int vc, input logic [1:0] ty, input logic [13:0] d);
    mkflit = {1'b1, 5'(vc), ty, d};
  endfunction

  // One clock: outputs then reflect the decision made in the previous cycle
  task automatic tick();
    @(posedge clk);
    #1;
    in_cycle = in_cycle + 16'd1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    can_inject = 1'b1;
    cr_in      = '0;
    tick();
    tick();
    rst      = 1'b0;
    in_cycle = 16'd0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_flit !== 22'h0) begin n_fail++; $display("FAIL reset_flit: got %h want 000000", out_flit); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", load_ready); end
    n_checks++;
    if (dut.rr_q !== '0) begin n_fail++; $display("FAIL reset_rr: got %0d want 0", dut.rr_q); end
    for (int v = 0; v < NUMVCS; v++) begin
      n_checks++;
      if (dut.credit_q[v] !== 3'(VCBUFSZ)) begin
        n_fail++; $display("FAIL reset_credit%0d: got %0d want %0d", v, dut.credit_q[v], VCBUFSZ);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    load_valid = 1'b1; load_cycle = 16'd5; load_dest = 14'h0012; load_len = 4'd1;
    sb.push_back('{flit: 22'h20C012, cyc: 16'd6});
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (out_flit[21] === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL single_extra: got %h at cycle %0d, none expected", out_flit, in_cycle);
        end else begin
          e = sb.pop_front();
          if (out_flit !== e.flit || in_cycle !== e.cyc) begin
            n_fail++; $display("FAIL single_flit: got %h@%0d want %h@%0d", out_flit, in_cycle, e.flit, e.cyc);
          end
        end
      end
      if (in_cycle == 16'd5) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_wait: got %b want 1", busy); end
      end
      if (in_cycle == 16'd6) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_done: got %b want 0", busy); end
      end
      tick();
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL single_missing: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_packet();
    do_reset();
    load_valid = 1'b1; load_cycle = 16'd0; load_dest = 14'h02AB; load_len = 4'd3;
    sb.push_back('{flit: 22'h2042AB, cyc: 16'd2});
    sb.push_back('{flit: 22'h2002AB, cyc: 16'd3});
    sb.push_back('{flit: 22'h2082AB, cyc: 16'd4});
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (out_flit[21] === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL packet_extra: got %h at cycle %0d, none expected", out_flit, in_cycle);
        end else begin
          e = sb.pop_front();
          if (out_flit !== e.flit || in_cycle !== e.cyc) begin
            n_fail++; $display("FAIL packet_flit: got %h@%0d want %h@%0d", out_flit, in_cycle, e.flit, e.cyc);
          end
        end
      end
      tick();
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL packet_missing: got %0d left want 0", sb.size()); end
    n_checks++;
    if (dut.credit_q[0] !== 3'd1) begin n_fail++; $display("FAIL packet_credit0: got %0d want 1", dut.credit_q[0]); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL packet_busy: got %b want 0", busy); end
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      if (out_flit[21] === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL exhaust_extra: got %h at cycle %0d, none expected", out_flit, in_cycle);
        end else begin
          e = sb.pop_front();
          if (out_flit !== e.flit || in_cycle !== e.cyc) begin
            n_fail++; $display("FAIL exhaust_flit: got %h@%0d want %h@%0d", out_flit, in_cycle, e.flit, e.cyc);
          end
        end
      end
      if (k == 19) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL exhaust_stall_busy: got %b want 1", busy); end
      end
      load_valid = (k < 17);
      load_cycle = 16'd0;
      load_dest  = 14'h100 + 14'(k);
      load_len   = 4'd1;
      if (k < 16) sb.push_back('{flit: mkflit(k % 4, 2'b11, 14'h100 + 14'(k)), cyc: 16'(k + 2)});
      cr_in = '0;
      if (k == 20) begin
        cr_in = {1'b1, 5'd2, 16'd0};
        sb.push_back('{flit: mkflit(2, 2'b11, 14'h110), cyc: 16'd22});
      end
      tick();
    end
    load_valid = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL exhaust_missing: got %0d left want 0", sb.size()); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL exhaust_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_hold();
    do_reset();
    for (int k = 0; k < 14; k++) begin
      if (out_flit[21] === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL hold_extra: got %h at cycle %0d, none expected", out_flit, in_cycle);
        end else begin
          e = sb.pop_front();
          if (out_flit !== e.flit || in_cycle !== e.cyc) begin
            n_fail++; $display("FAIL hold_flit: got %h@%0d want %h@%0d", out_flit, in_cycle, e.flit, e.cyc);
          end
        end
      end
      if (k == 4) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy: got %b want 1", busy); end
      end
      load_valid = (k == 0);
      load_cycle = 16'd0; load_dest = 14'h0055; load_len = 4'd4;
      if (k == 0) begin
        sb.push_back('{flit: mkflit(0, 2'b01, 14'h0055), cyc: 16'd2});
        sb.push_back('{flit: mkflit(0, 2'b00, 14'h0055), cyc: 16'd6});
        sb.push_back('{flit: mkflit(0, 2'b00, 14'h0055), cyc: 16'd7});
        sb.push_back('{flit: mkflit(0, 2'b10, 14'h0055), cyc: 16'd8});
      end
      can_inject = !(k >= 2 && k <= 4);
      tick();
    end
    can_inject = 1'b1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL hold_missing: got %0d left want 0", sb.size()); end
`ifdef INJ_STATS_EN
    n_checks++;
    if (stat_flits !== 32'd4) begin n_fail++; $display("FAIL hold_stat_flits: got %0d want 4", stat_flits); end
    n_checks++;
    if (stat_stall !== 32'd3) begin n_fail++; $display("FAIL hold_stat_stall: got %0d want 3", stat_stall); end
`endif
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int k = 0; k < 26; k++) begin
      if (out_flit[21] === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL full_extra: got %h at cycle %0d, none expected", out_flit, in_cycle);
        end else begin
          e = sb.pop_front();
          if (out_flit !== e.flit || in_cycle !== e.cyc) begin
            n_fail++; $display("FAIL full_flit: got %h@%0d want %h@%0d", out_flit, in_cycle, e.flit, e.cyc);
          end
        end
      end
      if (k <= 8) begin
        n_checks++;
        if (load_ready !== (k < 8)) begin
          n_fail++; $display("FAIL full_ready%0d: got %b want %b", k, load_ready, (k < 8));
        end
      end
      load_valid = (k <= 8);
      load_cycle = 16'd0;
      load_dest  = 14'h200 + 14'(k);
      load_len   = 4'd1;
      if (k < 8) sb.push_back('{flit: mkflit(k % 4, 2'b11, 14'h200 + 14'(k)), cyc: 16'(k + 10)});
      can_inject = (k >= 9);
      tick();
    end
    load_valid = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL full_missing: got %0d left want 0", sb.size()); end
    n_checks++;
    if (busy !== 1'b0 || load_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_drained: got busy=%b ready=%b want busy=0 ready=1", busy, load_ready);
    end
  endtask

  task automatic test_credit_return();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (out_flit[21] === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL credit_extra: got %h at cycle %0d, none expected", out_flit, in_cycle);
        end else begin
          e = sb.pop_front();
          if (out_flit !== e.flit || in_cycle !== e.cyc) begin
            n_fail++; $display("FAIL credit_flit: got %h@%0d want %h@%0d", out_flit, in_cycle, e.flit, e.cyc);
          end
        end
      end
      if (k == 2) begin
        n_checks++;
        if (dut.credit_q[0] !== 3'd4) begin n_fail++; $display("FAIL credit_same_edge: got %0d want 4", dut.credit_q[0]); end
      end
      if (k == 4) begin
        n_checks++;
        if (dut.credit_q[1] !== 3'd3) begin n_fail++; $display("FAIL credit_bad_vc: got %0d want 3", dut.credit_q[1]); end
      end
      if (k == 5) begin
        n_checks++;
        if (dut.credit_q[1] !== 3'd4) begin n_fail++; $display("FAIL credit_return: got %0d want 4", dut.credit_q[1]); end
      end
      if (k == 6) begin
        n_checks++;
        if (dut.credit_q[1] !== 3'd4) begin n_fail++; $display("FAIL credit_saturate: got %0d want 4", dut.credit_q[1]); end
      end
      load_valid = (k == 0 || k == 2);
      load_cycle = 16'd0; load_dest = 14'h0030 + 14'(k); load_len = 4'd1;
      if (k == 0) sb.push_back('{flit: mkflit(0, 2'b11, 14'h0030), cyc: 16'd2});
      if (k == 2) sb.push_back('{flit: mkflit(1, 2'b11, 14'h0032), cyc: 16'd4});
      case (k)
        1:       cr_in = {1'b1, 5'd0, 16'd0};
        3:       cr_in = {1'b1, 5'd5, 16'd0};
        4, 5:    cr_in = {1'b1, 5'd1, 16'd0};
        default: cr_in = '0;
      endcase
      tick();
    end
    cr_in = '0;
    load_valid = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL credit_missing: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (out_flit[21] === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL midrst_extra: got %h at cycle %0d, none expected", out_flit, in_cycle);
        end else begin
          e = sb.pop_front();
          if (out_flit !== e.flit || in_cycle !== e.cyc) begin
            n_fail++; $display("FAIL midrst_flit: got %h@%0d want %h@%0d", out_flit, in_cycle, e.flit, e.cyc);
          end
        end
      end
      if (k == 5) begin
        n_checks++;
        if (out_flit !== 22'h0 || busy !== 1'b0 || load_ready !== 1'b1) begin
          n_fail++; $display("FAIL midrst_outputs: got flit=%h busy=%b ready=%b want 000000/0/1", out_flit, busy, load_ready);
        end
        for (int v = 0; v < NUMVCS; v++) begin
          n_checks++;
          if (dut.credit_q[v] !== 3'(VCBUFSZ)) begin
            n_fail++; $display("FAIL midrst_credit%0d: got %0d want %0d", v, dut.credit_q[v], VCBUFSZ);
          end
        end
      end
      load_valid = (k == 0);
      load_cycle = 16'd0; load_dest = 14'h0077; load_len = 4'd5;
      if (k == 0) begin
        sb.push_back('{flit: mkflit(0, 2'b01, 14'h0077), cyc: 16'd2});
        sb.push_back('{flit: mkflit(0, 2'b00, 14'h0077), cyc: 16'd3});
        sb.push_back('{flit: mkflit(0, 2'b00, 14'h0077), cyc: 16'd4});
      end
      rst = (k == 4);
      tick();
    end
    rst = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL midrst_missing: got %0d left want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_packet();
    test_credit_exhaust();
    test_hold();
    test_fifo_full();
    test_credit_return();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
